cfu_l2_l1_shim: RTL



---
 rtl/cfu_l2_l1_shim_pkg.sv | 21 ++
 rtl/cfu_l2_l1_shim_queue.sv | 53 +++++
 rtl/cfu_l2_l1_shim.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cfu_l2_l1_shim_pkg.sv
// Shared status type, widths and elaboration-time parameter checks for the
// CFU-L2 to CFU-L1 shim.
package cfu_l2_l1_shim_pkg;

  localparam int CFU_STATUS_W = 3;

  typedef enum logic [CFU_STATUS_W-1:0] {
    CFU_STATUS_OK      = 3'd0,
    CFU_STATUS_ERR     = 3'd1,
    CFU_STATUS_ILLEGAL = 3'd2
  } cfu_status_e;

  function automatic bit check_param(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

  function automatic bit check_param_pos(input int value);
    return value >= 1;
  endfunction

endpackage

// File: rtl/cfu_l2_l1_shim_queue.sv
// Response FIFO for the shim: N entries of W bits, head visible on rdata.
// The caller never pushes into a full queue without a simultaneous pop.
module cfu_l2_l1_shim_queue #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  logic [W-1:0]  mem [N];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full   = (cnt == CW'(N));
  assign empty  = (cnt == '0);
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; cnt and the pointers
  // are, and an empty queue never exposes mem to the consumer.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cfu_l2_l1_shim.sv
// CFU-L2 (valid/ready) target port to CFU-L1 (fixed latency) leaf adapter.
// Optional latency-protocol checker: define CFU_L2_L1_SHIM_LAT_CHECK_EN.
module cfu_l2_l1_shim
  import cfu_l2_l1_shim_pkg::*;
#(
  parameter int CFU_STATE_ID_W = 1,
  parameter int CFU_FUNC_ID_W  = 10,
  parameter int CFU_INSN_W     = 0,
  parameter int CFU_DATA_W     = 32,
  parameter int LATENCY        = 2,
  parameter int DEPTH          = 8,
  localparam int INSN_W        = (CFU_INSN_W > 0) ? CFU_INSN_W : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CFU_STATE_ID_W-1:0] req_state,
  input  logic [CFU_FUNC_ID_W-1:0]  req_func,
  input  logic [INSN_W-1:0]         req_insn,
  input  logic [CFU_DATA_W-1:0]     req_data0,
  input  logic [CFU_DATA_W-1:0]     req_data1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [CFU_STATUS_W-1:0]   resp_status,
  output logic [CFU_DATA_W-1:0]     resp_data,
  output logic                      l1_clk_en,
  output logic                      l1_req_valid,
  output logic [CFU_STATE_ID_W-1:0] l1_req_state,
  output logic [CFU_FUNC_ID_W-1:0]  l1_req_func,
  output logic [INSN_W-1:0]         l1_req_insn,
  output logic [CFU_DATA_W-1:0]     l1_req_data0,
  output logic [CFU_DATA_W-1:0]     l1_req_data1,
  input  logic                      l1_resp_valid,
  input  logic [CFU_STATUS_W-1:0]   l1_resp_status,
  input  logic [CFU_DATA_W-1:0]     l1_resp_data,
  output logic                      lat_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = CFU_STATUS_W + CFU_DATA_W;

  if (!check_param(LATENCY, 0, 15)) begin : g_bad_latency
    $error("cfu_l2_l1_shim: LATENCY must be in 0..15");
  end
  if (!check_param_pos(DEPTH)) begin : g_bad_depth
    $error("cfu_l2_l1_shim: DEPTH must be at least 1");
  end

  logic [CNT_W-1:0] count;
  logic             req_hs;
  logic             resp_hs;
  logic             push;
  logic             q_full;
  logic             q_empty;
  logic [ENT_W-1:0] q_rdata;

  assign l1_clk_en  = clk_en;
  // Credits cover the leaf pipe and the buffer, so ready depends on count only.
  assign req_ready  = (count < CNT_W'(DEPTH));
  assign req_hs     = clk_en && req_valid && req_ready;
  assign resp_valid = !q_empty;
  assign resp_hs    = clk_en && resp_valid && resp_ready;
  assign push       = clk_en && l1_resp_valid && (!q_full || resp_hs);
  assign {resp_status, resp_data} = resp_valid ? q_rdata : '0;

  // NOTE: all registered state uses non-blocking assignments so every
  // always_ff reads pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count        <= '0;
      l1_req_valid <= 1'b0;
      l1_req_state <= '0;
      l1_req_func  <= '0;
      l1_req_insn  <= '0;
      l1_req_data0 <= '0;
      l1_req_data1 <= '0;
    end else if (clk_en) begin
      l1_req_valid <= req_hs;
      if (req_hs) begin
        l1_req_state <= req_state;
        l1_req_func  <= req_func;
        l1_req_insn  <= req_insn;
        l1_req_data0 <= req_data0;
        l1_req_data1 <= req_data1;
      end
      if (req_hs && !resp_hs)      count <= count + CNT_W'(1);
      else if (!req_hs && resp_hs) count <= count - CNT_W'(1);
    end
  end

  cfu_l2_l1_shim_queue #(
    .W (ENT_W),
    .N (DEPTH)
  ) u_resp_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({l1_resp_status, l1_resp_data}),
    .pop   (resp_hs),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

`ifdef CFU_L2_L1_SHIM_LAT_CHECK_EN
  // exp_sr[k] is set when a request was issued to the leaf k cycles ago.
  logic [LATENCY:0]   exp_sr;
  logic [LATENCY+1:0] exp_shift;
  logic               drop;
  logic               lat_err_q;

  assign exp_shift = {exp_sr, req_hs};
  assign drop      = clk_en && l1_resp_valid && !push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_sr    <= '0;
      lat_err_q <= 1'b0;
    end else if (clk_en) begin
      exp_sr <= exp_shift[LATENCY:0];
      if ((l1_resp_valid != exp_sr[LATENCY]) || drop) lat_err_q <= 1'b1;
    end
  end

  assign lat_err = lat_err_q;
`else
  assign lat_err = 1'b0;
`endif

endmodule
